count_event_queue: RTL and testbench

- Downstream consumer of a free-running wrap-around counter (count width W).
- Samples the counter value, detects wrap events and programmable-threshold hits, and queues timestamped events in a DEPTH-entry FIFO behind a valid/ready output.
- Events that arrive while the queue is full are dropped and tallied.
- Serves as the event source for checker and model-checking harnesses around counter blocks.

---
 rtl/count_event_queue.sv | 120 ++++++++++++
 tb/tb_count_event_queue.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/count_event_queue.sv
// Counter event source: detects wraps and threshold hits on a sampled counter and queues
// timestamped events in a FIFO. Define COUNT_EVENT_ASSERT_EN to compile in checker properties.
module count_event_queue #(
    parameter int unsigned W      = 10,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cnt_vld,
    input  logic [W-1:0]               cnt,
    input  logic [W-1:0]               thresh,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [1:0]                 evt_kind,
    output logic [W-1:0]               evt_stamp,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic                       overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = $clog2(DEPTH+1);
    localparam logic [OccW-1:0] DepthOcc = OccW'(DEPTH);

    typedef enum logic [0:0] {StIdle, StTrack} trk_state_e;

    trk_state_e state_q, state_d;
    logic [W-1:0] prev_q, prev_d;

    logic [1:0]   kind_mem  [DEPTH];
    logic [W-1:0] stamp_mem [DEPTH];

    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]   occ_q, occ_d;
    logic [DROP_W-1:0] drop_cnt_q;
    logic              overflow_q;

    logic wrap, hit, event_now, full, push, pop, drop;

    // Tracker: the previous sample only becomes meaningful once the first sample is taken.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        if (cnt_vld) begin
            prev_d  = cnt;
            state_d = StTrack;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
        end
    end

    // Detection; a held value equal to the threshold counts once.
    always_comb begin
        wrap      = (state_q == StTrack) && cnt_vld && (cnt < prev_q);
        hit       = cnt_vld && (cnt == thresh) && !((state_q == StTrack) && (prev_q == thresh));
        event_now = wrap || hit;
        full      = (occ_q == DepthOcc);
        pop       = evt_valid && evt_ready;
        push      = event_now && (!full || pop);
        drop      = event_now && full && !pop;
        occ_d     = occ_q + OccW'(push) - OccW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            kind_mem[wr_ptr_q]  <= {hit, wrap};
            stamp_mem[wr_ptr_q] <= cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q <= occ_d;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        evt_valid = (occ_q != '0);
        evt_kind  = evt_valid ? kind_mem[rd_ptr_q]  : 2'b00;
        evt_stamp = evt_valid ? stamp_mem[rd_ptr_q] : '0;
        occupancy = occ_q;
        drop_cnt  = drop_cnt_q;
        overflow  = overflow_q;
    end

`ifdef COUNT_EVENT_ASSERT_EN
    logic init_q = 1'b1;
    always_ff @(posedge clk) init_q <= 1'b0;

    a0: assert property (@(posedge clk) disable iff (rst) occupancy <= DepthOcc);
    a1: assert property (@(posedge clk) disable iff (rst) evt_valid == (occupancy != '0));
    a2: assert property (@(posedge clk) disable iff (rst)
            (evt_valid && !evt_ready) |=> ($stable(evt_kind) && $stable(evt_stamp)));
    a3: assert property (@(posedge clk) disable iff (rst) 1'b1 |=> drop_cnt >= $past(drop_cnt));
    a4: assert property (@(posedge clk) disable iff (rst) overflow |=> overflow);
    c_init: assume property (@(posedge clk) rst == init_q);
`endif

endmodule

// File: tb/tb_count_event_queue.sv
// Directed bench for count_event_queue with hand-computed expectations.
module tb_count_event_queue;

    localparam int unsigned W = 10;

    logic         clk = 1'b0;
    logic         rst, cnt_vld, evt_ready, evt_valid, overflow;
    logic [W-1:0] cnt, thresh, evt_stamp;
    logic [1:0]   evt_kind;
    logic [2:0]   occupancy;
    logic [7:0]   drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    count_event_queue #(.W(W), .DEPTH(4), .DROP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_vld   (cnt_vld),
        .cnt       (cnt),
        .thresh    (thresh),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_kind  (evt_kind),
        .evt_stamp (evt_stamp),
        .occupancy (occupancy),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [W-1:0] v);
        cnt_vld = 1'b1;
        cnt     = v;
        step();
    endtask

    int unsigned drain_exp [4] = '{20, 30, 40, 60};
    int unsigned hi_v [5] = '{100, 200, 300, 400, 500};
    int unsigned lo_v [5] = '{10, 20, 30, 40, 50};

    initial begin
        rst = 1'b1; cnt_vld = 1'b0; cnt = '0; thresh = 10'd5; evt_ready = 1'b1;
        step();
        rst = 1'b0;
        check("rst_valid", evt_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_ovf", overflow, 0);
        check("rst_kind", evt_kind, 0);
        check("rst_stamp", evt_stamp, 0);

        // max -> 0 wrap
        sample(10'd1020); sample(10'd1021); sample(10'd1022); sample(10'd1023);
        check("wrap_pre_valid", evt_valid, 0);
        sample(10'd0);
        check("wrap_valid", evt_valid, 1);
        check("wrap_kind", evt_kind, 1);
        check("wrap_stamp", evt_stamp, 0);
        cnt_vld = 1'b0;
        step();
        check("wrap_one_cycle", evt_valid, 0);

        // threshold hit with held value
        thresh = 10'd7;
        sample(10'd6);
        check("th_pre", evt_valid, 0);
        sample(10'd7);
        check("th_valid", evt_valid, 1);
        check("th_kind", evt_kind, 2);
        check("th_stamp", evt_stamp, 7);
        sample(10'd7);
        check("th_hold1", evt_valid, 0);
        sample(10'd7);
        check("th_hold2", evt_valid, 0);
        sample(10'd8);
        check("th_hold3", evt_valid, 0);

        // wrap and hit together
        thresh = 10'd0;
        sample(10'd1023);
        check("both_pre", evt_valid, 0);
        sample(10'd0);
        check("both_kind", evt_kind, 3);
        check("both_stamp", evt_stamp, 0);
        cnt_vld = 1'b0;
        step();
        check("both_drained", occupancy, 0);

        // five wraps under backpressure
        thresh = 10'd1000;
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample(hi_v[i][W-1:0]);
            sample(lo_v[i][W-1:0]);
        end
        check("full_occ", occupancy, 4);
        check("full_drop", drop_cnt, 1);
        check("full_ovf", overflow, 1);
        check("full_head", evt_stamp, 10);

        // full queue: push with simultaneous pop is accepted
        sample(10'd600);
        check("full_nopush_drop", drop_cnt, 1);
        evt_ready = 1'b1;
        sample(10'd60);
        check("pp_occ", occupancy, 4);
        check("pp_drop", drop_cnt, 1);
        check("pp_head", evt_stamp, 20);

        cnt_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_stamp%0d", i), evt_stamp, drain_exp[i]);
            step();
        end
        check("drain_occ", occupancy, 0);
        check("drain_valid", evt_valid, 0);
        check("drain_ovf", overflow, 1);

        // reset mid-drain
        evt_ready = 1'b0;
        sample(10'd700); sample(10'd70);
        sample(10'd800); sample(10'd80);
        sample(10'd900); sample(10'd90);
        check("mid_occ", occupancy, 3);
        evt_ready = 1'b1;
        rst = 1'b1;
        sample(10'd5);
        rst = 1'b0;
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_valid", evt_valid, 0);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_ovf", overflow, 0);
        thresh = 10'd5;
        sample(10'd0);
        check("idle_no_wrap", evt_valid, 0);

        // hit on the first sample after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample(10'd5);
        check("idle_hit_valid", evt_valid, 1);
        check("idle_hit_kind", evt_kind, 2);
        check("idle_hit_stamp", evt_stamp, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
